// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_loader
//  Description : Receives a framed byte stream, assembles big-endian 32-bit
//                words, writes them into the instruction memory and verifies
//                a mod-256 checksum. Holds the core in reset until a frame
//                has loaded cleanly.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_boot_loader #(
    parameter int          DEPTH = 64,
    parameter logic [31:0] BASE  = 32'h0,
    parameter int          CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,        // active-low, asynchronous
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        load_req,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    // One extra bit so a word count equal to DEPTH is representable.
    localparam int IDX_W = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t             state_q,    state_d;
    logic [7:0]         len_lo_q,   len_lo_d;
    logic [IDX_W-1:0]   len_q,      len_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic [1:0]         bcnt_q,     bcnt_d;
    logic [31:0]        word_q,     word_d;
    logic [7:0]         sum_q,      sum_d;
    logic               wr_en_q,    wr_en_d;
    logic [31:0]        wr_addr_q,  wr_addr_d;
    logic [31:0]        wr_data_q,  wr_data_d;

    logic               w_accept;
    logic [CNT_W-1:0]   w_len;
    logic [31:0]        w_word;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [31:0]        w_addr;

    // The loader stops taking bytes once a frame has finished either way.
    assign in_ready  = (state_q != S_DONE) && (state_q != S_ERR);
    assign w_accept  = in_valid && in_ready;
    assign w_len     = CNT_W'({in_data, len_lo_q});
    assign w_word    = {word_q[23:0], in_data};
    assign w_idx_nxt = idx_q + IDX_W'(1);
    assign w_addr    = BASE + {{(30-IDX_W){1'b0}}, idx_q, 2'b00};

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = (state_q == S_DONE);
    assign err     = (state_q == S_ERR);
    assign cpu_rst = (state_q != S_DONE);

    // State and datapath registers; reset discards all frame progress at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_LEN0;
            len_lo_q  <= 8'h00;
            len_q     <= '0;
            idx_q     <= '0;
            bcnt_q    <= 2'd0;
            word_q    <= 32'h0;
            sum_q     <= 8'h00;
            wr_en_q   <= 1'b0;
            wr_addr_q <= BASE;
            wr_data_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            len_lo_q  <= len_lo_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            bcnt_q    <= bcnt_d;
            word_q    <= word_d;
            sum_q     <= sum_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Frame parser: next state, word assembly, checksum and write strobe.
    always_comb begin
        state_d   = state_q;
        len_lo_d  = len_lo_q;
        len_d     = len_q;
        idx_d     = idx_q;
        bcnt_d    = bcnt_q;
        word_d    = word_q;
        sum_d     = sum_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_LEN0: begin
                if (w_accept) begin
                    len_lo_d = in_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (w_accept) begin
                    if ((w_len == '0) || (w_len > CNT_W'(DEPTH))) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = w_len[IDX_W-1:0];
                        idx_d   = '0;
                        bcnt_d  = 2'd0;
                        sum_d   = 8'h00;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    word_d = w_word;
                    sum_d  = sum_q + in_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = w_addr;
                        wr_data_d = w_word;
                        idx_d     = w_idx_nxt;
                        if (w_idx_nxt == len_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    state_d = (in_data == sum_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (load_req) begin
                    state_d   = S_LEN0;
                    len_lo_d  = 8'h00;
                    len_d     = '0;
                    idx_d     = '0;
                    bcnt_d    = 2'd0;
                    word_d    = 32'h0;
                    sum_d     = 8'h00;
                    wr_addr_d = BASE;
                end
            end
            default: begin
                state_d = S_LEN0;
            end
        endcase
    end

endmodule
`default_nettype wire
